// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared types, width derivation and saturation limits for the dot-product engine
// Contents:
//   dot_state_t  : controller state encoding
//   acc_width()  : accumulator width that cannot overflow for a given element width and length
//   sat_umax()   : unsigned saturation value for a res_w-bit result (low res_w bits valid)
//   sat_smax()   : signed positive saturation bit pattern for a res_w-bit result
//   sat_smin()   : signed negative saturation bit pattern for a res_w-bit result
package dot_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_A = 3'd1,
      FETCH_B = 3'd2,
      ACC     = 3'd3,
      FINISH  = 3'd4
   } dot_state_t;

   // Product needs 2*data_w bits, the sum of vec_len products adds clog2(vec_len),
   // and one more bit keeps the signed range symmetric.
   function automatic int acc_width(input int data_w, input int vec_len);
      return 2 * data_w + $clog2(vec_len) + 1;
   endfunction

   function automatic logic [63:0] sat_umax(input int res_w);
      return (64'd1 << res_w) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_smax(input int res_w);
      return (64'd1 << (res_w - 1)) - 64'd1;
   endfunction

   // Bit pattern of -2^(res_w-1) within res_w bits.
   function automatic logic [63:0] sat_smin(input int res_w);
      return 64'd1 << (res_w - 1);
   endfunction

endpackage

// File: rtl/dot_mac_slice.sv
// rtl/dot_mac_slice.sv - combinational extend-multiply-add step of the dot product
// Ports:
//   a, b        : DATA_W-bit operands
//   acc         : ACC_W-bit running sum
//   signed_mode : 1 = sign-extend operands, 0 = zero-extend
//   acc_next    : acc + ext(a) * ext(b), ACC_W bits
module dot_mac_slice #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [ACC_W-1:0]  acc,
   input  logic              signed_mode,
   output logic [ACC_W-1:0]  acc_next
);

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W-1:0] b_ext;

   assign a_ext = {{(ACC_W - DATA_W){signed_mode & a[DATA_W-1]}}, a};
   assign b_ext = {{(ACC_W - DATA_W){signed_mode & b[DATA_W-1]}}, b};

   // Modulo-2^ACC_W multiply gives the correct two's-complement low bits for
   // both modes, and the true product always fits in ACC_W bits.
   assign acc_next = acc + a_ext * b_ext;

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - fetches two vectors from scratch memory and multiply-accumulates them
// Build option: DOT_SAT_EN saturates result on overflow (default build truncates).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, signed_mode         : run request and operand mode (latched at start)
//   base_a, base_b             : vector base addresses (latched at start, wrap modulo 2^ADDR_W)
//   mem_addr, mem_rd_en        : read request to scratch memory
//   mem_rdata                  : read data, valid one cycle after the request
//   busy, done                 : run in progress / one-cycle result-valid pulse
//   result, overflow, acc_full : reduced result, range flag, full accumulator (held until next run)
module dot_product_engine
   import dot_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int VEC_LEN = 8,
   parameter  int ADDR_W  = 4,
   parameter  int RES_W   = 8,
   localparam int ACC_W   = acc_width(DATA_W, VEC_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              signed_mode,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [RES_W-1:0]  result,
   output logic              overflow,
   output logic [ACC_W-1:0]  acc_full
);

   localparam int               IDX_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

   dot_state_t        state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic              mode_r;
   logic [ADDR_W-1:0] base_a_r, base_b_r;
   logic [DATA_W-1:0] a_reg;
   logic [ACC_W-1:0]  acc, acc_next;
   logic              ovf_next;
   logic [RES_W-1:0]  res_next;

   dot_mac_slice #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .a           (a_reg),
      .b           (mem_rdata),
      .acc         (acc),
      .signed_mode (mode_r),
      .acc_next    (acc_next)
   );

   always_comb begin
      state_nxt = state;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = FETCH_A;
         end
         FETCH_A: begin
            mem_addr  = base_a_r + ADDR_W'(idx);
            mem_rd_en = 1'b1;
            state_nxt = FETCH_B;
         end
         FETCH_B: begin
            mem_addr  = base_b_r + ADDR_W'(idx);
            mem_rd_en = 1'b1;
            state_nxt = ACC;
         end
         ACC: begin
            state_nxt = (idx == LAST_IDX) ? FINISH : FETCH_A;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Range check on the final sum: unsigned needs all bits above RES_W clear,
   // signed needs the bits from RES_W-1 upward to be a pure sign extension.
   generate
      if (RES_W < ACC_W) begin : g_ovf
         logic [ACC_W-RES_W-1:0] hi_u;
         logic [ACC_W-RES_W:0]   hi_s;
         assign hi_u     = acc_next[ACC_W-1:RES_W];
         assign hi_s     = acc_next[ACC_W-1:RES_W-1];
         assign ovf_next = mode_r ? !((&hi_s) || !(|hi_s)) : (|hi_u);
      end else begin : g_no_ovf
         assign ovf_next = 1'b0;
      end
   endgenerate

`ifdef DOT_SAT_EN
   localparam logic [63:0] UMAX64 = sat_umax(RES_W);
   localparam logic [63:0] SMAX64 = sat_smax(RES_W);
   localparam logic [63:0] SMIN64 = sat_smin(RES_W);

   always_comb begin
      res_next = acc_next[RES_W-1:0];
      if (ovf_next) begin
         if (!mode_r)                res_next = UMAX64[RES_W-1:0];
         else if (acc_next[ACC_W-1]) res_next = SMIN64[RES_W-1:0];
         else                        res_next = SMAX64[RES_W-1:0];
      end
   end
`else
   assign res_next = acc_next[RES_W-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         mode_r   <= 1'b0;
         base_a_r <= '0;
         base_b_r <= '0;
         a_reg    <= '0;
         acc      <= '0;
         result   <= '0;
         overflow <= 1'b0;
         acc_full <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_r   <= signed_mode;
                  base_a_r <= base_a;
                  base_b_r <= base_b;
                  acc      <= '0;
                  idx      <= '0;
               end
            end
            FETCH_B: a_reg <= mem_rdata;
            ACC: begin
               acc <= acc_next;
               if (idx != LAST_IDX) begin
                  idx <= idx + 1'b1;
               end else begin
                  // Loaded on the edge into FINISH so they are valid alongside done.
                  result   <= res_next;
                  overflow <= ovf_next;
                  acc_full <= acc_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
